z_result_unloader: RTL and testbench

- Captures 64-bit ALU results (z_high:z_low) into a small result queue and unloads each one onto the 32-bit datapath bus as two words: low word first, then high word.
- Bus access is requested and granted with a req/grant handshake.
- Sits between the ALU outputs (AND_32, ADD_32, MUL_32, …) and the shared bus. It is the consumer end of the ALU result interface.

---
 rtl/z_result_unloader_if.sv | 37 +++
 rtl/z_result_unloader.sv | 128 ++++++++++++
 tb/tb_z_result_unloader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/z_result_unloader_if.sv
`default_nettype none
// ============================================================================
//  Module   : z_result_unloader_if
//  Purpose  : ALU-result input and shared-bus output signals of the result
//             unloader, bundled with a modport for each side.
//  Revision : 1.0  initial release
// ============================================================================
interface z_result_unloader_if #(
    parameter int WIDTH = 32
);
    // ALU result side
    logic             z_valid;
    logic [WIDTH-1:0] z_low;
    logic [WIDTH-1:0] z_high;
    logic             z_ready;
    // Shared bus side
    logic             bus_req;
    logic             bus_grant;
    logic [WIDTH-1:0] bus_out;
    logic             bus_drive;
    logic             word_sel;
    logic             done;
    logic             ovf;

    // The unloader itself: consumes ALU results, drives the bus
    modport master (
        input  z_valid, z_low, z_high, bus_grant,
        output z_ready, bus_req, bus_out, bus_drive, word_sel, done, ovf
    );

    // Environment: ALU producer plus bus arbiter/observer
    modport slave (
        output z_valid, z_low, z_high, bus_grant,
        input  z_ready, bus_req, bus_out, bus_drive, word_sel, done, ovf
    );
endinterface
`default_nettype wire

// File: rtl/z_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : z_result_unloader
//  Purpose  : Queues 64-bit ALU results and unloads each onto the 32-bit
//             shared bus as two words (low, then high) after a req/grant
//             handshake. Drops and flags results offered while full.
//  Revision : 1.0  initial release
// ============================================================================
module z_result_unloader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          clr,
    z_result_unloader_if.master zif
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SEND_LO = 2'd2,
        S_SEND_HI = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic                 ovf_q;

    // Result storage is deliberately not reset; emptiness is tracked by count
    logic [WIDTH-1:0]     mem_lo_q [DEPTH];
    logic [WIDTH-1:0]     mem_hi_q [DEPTH];

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bus_req;
    logic                 w_bus_drive;
    logic                 w_word_sel;
    logic                 w_done;
    logic [WIDTH-1:0]     w_bus_out;

    // Readiness comes from registered count only, so a same-cycle pop never
    // frees a slot for a push
    assign w_ready = (count_q != c_FULL);
    assign w_push  = zif.z_valid && w_ready;
    assign w_pop   = (state_q == S_SEND_HI);
    assign count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    // Queue bookkeeping, sticky overflow and FSM state register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (w_push)
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            if (zif.z_valid && !w_ready)
                ovf_q <= 1'b1;
        end
    end

    // Result storage write port
    always_ff @(posedge clk) begin
        if (!clr && w_push) begin
            mem_lo_q[wr_ptr_q] <= zif.z_low;
            mem_hi_q[wr_ptr_q] <= zif.z_high;
        end
    end

    // Next-state and Moore output decode from state and head entry
    always_comb begin
        state_d     = state_q;
        w_bus_req   = 1'b0;
        w_bus_drive = 1'b0;
        w_word_sel  = 1'b0;
        w_done      = 1'b0;
        w_bus_out   = '0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0)
                    state_d = S_REQ;
            end
            S_REQ: begin
                w_bus_req = 1'b1;
                if (zif.bus_grant)
                    state_d = S_SEND_LO;
            end
            S_SEND_LO: begin
                w_bus_req   = 1'b1;
                w_bus_drive = 1'b1;
                w_bus_out   = mem_lo_q[rd_ptr_q];
                state_d     = S_SEND_HI;
            end
            S_SEND_HI: begin
                w_bus_req   = 1'b1;
                w_bus_drive = 1'b1;
                w_word_sel  = 1'b1;
                w_done      = 1'b1;
                w_bus_out   = mem_hi_q[rd_ptr_q];
                // Every transfer re-arbitrates, even with entries left
                state_d     = (count_d != '0) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign zif.z_ready   = w_ready;
    assign zif.bus_req   = w_bus_req;
    assign zif.bus_drive = w_bus_drive;
    assign zif.word_sel  = w_word_sel;
    assign zif.done      = w_done;
    assign zif.bus_out   = w_bus_out;
    assign zif.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_z_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z_result_unloader
//  Purpose  : Directed scenarios followed by a randomized run against a
//             queue-based reference model of the result unloader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_z_result_unloader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    z_result_unloader_if #(.WIDTH(WIDTH)) zif ();

    z_result_unloader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .zif (zif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full bus-side output set for one cycle
    task automatic chk_bus(input string tag, input logic req, input logic drive,
                           input logic [31:0] out, input logic ws, input logic dn);
        chk({tag, "_req"},   64'(zif.bus_req),   64'(req));
        chk({tag, "_drive"}, 64'(zif.bus_drive), 64'(drive));
        chk({tag, "_out"},   64'(zif.bus_out),   64'(out));
        chk({tag, "_ws"},    64'(zif.word_sel),  64'(ws));
        chk({tag, "_done"},  64'(zif.done),      64'(dn));
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo);
        zif.z_valid = 1'b1;
        zif.z_high  = hi;
        zif.z_low   = lo;
    endtask

    // Reference model: FIFO of accepted results and sticky overflow flag
    logic [63:0] q[$];
    logic        ovf_m;
    logic        prev_done;
    logic        accept;
    logic        pop;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        clr           = 1'b1;
        zif.z_valid   = 1'b0;
        zif.z_low     = '0;
        zif.z_high    = '0;
        zif.bus_grant = 1'b0;
        tick();
        tick();
        clr = 1'b0;

        // ---- reset state
        chk_bus("reset", 0, 0, 32'h0, 0, 0);
        chk("reset_ready", 64'(zif.z_ready), 64'(1));
        chk("reset_ovf",   64'(zif.ovf),     64'(0));

        // ---- single result, grant tied high
        zif.bus_grant = 1'b1;
        push(32'h0000_0000, 32'h0000_AAAA);
        tick();
        zif.z_valid = 1'b0;
        chk_bus("single_t0", 0, 0, 32'h0, 0, 0);
        tick();
        chk_bus("single_req", 1, 0, 32'h0, 0, 0);
        tick();
        chk_bus("single_lo", 1, 1, 32'h0000_AAAA, 0, 0);
        tick();
        chk_bus("single_hi", 1, 1, 32'h0000_0000, 1, 1);
        tick();
        chk_bus("single_idle", 0, 0, 32'h0, 0, 0);

        // ---- grant stall for five REQ cycles
        zif.bus_grant = 1'b0;
        push(32'hFFFF_0000, 32'hAAAA_0000);
        tick();
        zif.z_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_bus("stall_req", 1, 0, 32'h0, 0, 0);
        end
        zif.bus_grant = 1'b1;
        tick();
        chk_bus("stall_lo", 1, 1, 32'hAAAA_0000, 0, 0);
        tick();
        chk_bus("stall_hi", 1, 1, 32'hFFFF_0000, 1, 1);
        tick();
        chk_bus("stall_idle", 0, 0, 32'h0, 0, 0);

        // ---- fill and overflow
        zif.bus_grant = 1'b0;
        push(32'h1, 32'h11);
        tick();
        chk("fill_ready_a", 64'(zif.z_ready), 64'(1));
        push(32'h2, 32'h22);
        tick();
        chk("fill_ready_b", 64'(zif.z_ready), 64'(0));
        chk("fill_ovf_b",   64'(zif.ovf),     64'(0));
        push(32'h3, 32'h33);
        tick();
        zif.z_valid = 1'b0;
        chk("fill_ovf_c",   64'(zif.ovf),     64'(1));
        chk("fill_ready_c", 64'(zif.z_ready), 64'(0));
        chk_bus("fill_req", 1, 0, 32'h0, 0, 0);
        zif.bus_grant = 1'b1;
        tick();
        chk_bus("fill_a_lo", 1, 1, 32'h11, 0, 0);
        tick();
        chk_bus("fill_a_hi", 1, 1, 32'h1, 1, 1);
        tick();
        chk_bus("fill_rearb", 1, 0, 32'h0, 0, 0);
        tick();
        chk_bus("fill_b_lo", 1, 1, 32'h22, 0, 0);
        tick();
        chk_bus("fill_b_hi", 1, 1, 32'h2, 1, 1);
        tick();
        chk_bus("fill_idle", 0, 0, 32'h0, 0, 0);
        chk("fill_ovf_sticky", 64'(zif.ovf), 64'(1));

        // ---- grant dropped during SEND_LO
        push(32'hBEEF_0002, 32'hBEEF_0001);
        tick();
        zif.z_valid = 1'b0;
        tick();
        chk_bus("gdrop_req", 1, 0, 32'h0, 0, 0);
        tick();
        zif.bus_grant = 1'b0;
        chk_bus("gdrop_lo", 1, 1, 32'hBEEF_0001, 0, 0);
        tick();
        chk_bus("gdrop_hi", 1, 1, 32'hBEEF_0002, 1, 1);
        tick();
        chk_bus("gdrop_idle", 0, 0, 32'h0, 0, 0);

        // ---- push during unload, pointers wrap
        zif.bus_grant = 1'b1;
        push(32'hA000_00A1, 32'hA000_00A0);
        tick();
        zif.z_valid = 1'b0;
        tick();
        tick();
        chk_bus("pdu_a_lo", 1, 1, 32'hA000_00A0, 0, 0);
        push(32'hB000_00B1, 32'hB000_00B0);
        tick();
        zif.z_valid = 1'b0;
        chk_bus("pdu_a_hi", 1, 1, 32'hA000_00A1, 1, 1);
        tick();
        chk_bus("pdu_req", 1, 0, 32'h0, 0, 0);
        tick();
        chk_bus("pdu_b_lo", 1, 1, 32'hB000_00B0, 0, 0);
        tick();
        chk_bus("pdu_b_hi", 1, 1, 32'hB000_00B1, 1, 1);
        tick();
        chk_bus("pdu_idle", 0, 0, 32'h0, 0, 0);

        // ---- reset during SEND_LO
        push(32'hD000_0001, 32'hD000_0000);
        tick();
        zif.z_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_drive", 64'(zif.bus_drive), 64'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_bus("rst_mid", 0, 0, 32'h0, 0, 0);
        chk("rst_mid_ready", 64'(zif.z_ready), 64'(1));
        chk("rst_mid_ovf",   64'(zif.ovf),     64'(0));
        tick();
        chk_bus("rst_mid_empty", 0, 0, 32'h0, 0, 0);
        push(32'hE000_0001, 32'hE000_0000);
        tick();
        zif.z_valid = 1'b0;
        tick();
        chk_bus("rst_new_req", 1, 0, 32'h0, 0, 0);
        tick();
        chk_bus("rst_new_lo", 1, 1, 32'hE000_0000, 0, 0);
        tick();
        chk_bus("rst_new_hi", 1, 1, 32'hE000_0001, 1, 1);
        tick();
        chk_bus("rst_new_idle", 0, 0, 32'h0, 0, 0);

        // ---- randomized run against the reference model
        q.delete();
        ovf_m     = 1'b0;
        prev_done = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_ready", 64'(zif.z_ready), 64'(q.size() < DEPTH));
            chk("rnd_ovf",   64'(zif.ovf),     64'(ovf_m));
            if (prev_done)
                chk("rnd_gap", 64'(zif.bus_drive), 64'(0));
            pop = 1'b0;
            if (zif.bus_drive) begin
                if (q.size() == 0) begin
                    chk("rnd_drive_empty", 64'(zif.bus_drive), 64'(0));
                end else if (!zif.word_sel) begin
                    chk("rnd_lo",      64'(zif.bus_out), 64'(q[0][31:0]));
                    chk("rnd_lo_done", 64'(zif.done),    64'(0));
                end else begin
                    chk("rnd_hi",      64'(zif.bus_out), 64'(q[0][63:32]));
                    chk("rnd_hi_done", 64'(zif.done),    64'(1));
                    pop = 1'b1;
                end
            end else begin
                chk("rnd_idle_bus", {31'(0), zif.done, zif.bus_out}, 64'(0));
            end
            prev_done = zif.done;

            zif.z_valid   = ($urandom_range(0, 1) == 1);
            zif.z_low     = $urandom;
            zif.z_high    = $urandom;
            zif.bus_grant = ($urandom_range(0, 3) != 0);

            // Capacity is judged on occupancy before this edge's pop
            accept = zif.z_valid && (q.size() < DEPTH);
            if (zif.z_valid && !accept)
                ovf_m = 1'b1;
            if (pop)
                void'(q.pop_front());
            if (accept)
                q.push_back({zif.z_high, zif.z_low});
            tick();
        end

        // ---- drain with grant held, bounded
        zif.z_valid   = 1'b0;
        zif.bus_grant = 1'b1;
        for (int cyc = 0; cyc < 40 && q.size() != 0; cyc++) begin
            if (zif.bus_drive && zif.word_sel && q.size() != 0) begin
                chk("drain_hi", 64'(zif.bus_out), 64'(q[0][63:32]));
                void'(q.pop_front());
            end else if (zif.bus_drive && q.size() != 0) begin
                chk("drain_lo", 64'(zif.bus_out), 64'(q[0][31:0]));
            end
            tick();
        end
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
